// File: rtl/sfw_pkg.sv
// Shared types and constants for the sample FIFO writer.
// Holds the framing FSM state type, the default sync word and header field widths.
package sfw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_SEQ  = 2'd2,
    ST_DATA = 2'd3
  } sfw_state_e;

  localparam logic [31:0] SFW_SYNC_WORD = 32'h5344_5246;
  localparam int          SFW_SEQ_W     = 16;
  localparam int          SFW_LEN_W     = 16;

  // Second header word: frame sequence number in the upper half, frame length below.
  function automatic logic [31:0] sfw_seq_word(input logic [SFW_SEQ_W-1:0] seq,
                                               input logic [SFW_LEN_W-1:0] len);
    return {seq, len};
  endfunction

endpackage

// File: rtl/sample_fifo_writer_if.sv
// Sample input and FIFO write port of the sample FIFO writer.
// Handshake: a sample moves when s_valid and s_ready are both 1 on a wr_clk edge;
// the source holds s_i/s_q stable while s_valid=1 and s_ready=0. The FIFO takes
// fifo_din on every edge where fifo_wr_en=1; fifo_wr_en is never 1 with fifo_full=1.
interface sample_fifo_writer_if;

  logic        s_valid;
  logic [15:0] s_i;
  logic [15:0] s_q;
  logic        s_ready;
  logic [31:0] fifo_din;
  logic        fifo_wr_en;
  logic        fifo_full;

  // Writer side.
  modport master (
    input  s_valid, s_i, s_q, fifo_full,
    output s_ready, fifo_din, fifo_wr_en
  );

  // Sample source / FIFO side.
  modport slave (
    output s_valid, s_i, s_q, fifo_full,
    input  s_ready, fifo_din, fifo_wr_en
  );

endinterface

// File: rtl/sat_counter.sv
// 16-bit saturating event counter with asynchronous active-low clear.
module sat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] count
);

  // Count up on inc, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/sample_fifo_writer.sv
// Frames I/Q samples into an async FIFO: SYNC_WORD, {seq, len}, then FRAME_LEN
// samples packed {s_i, s_q}. Build option SFW_DROP_EN: when defined, samples are
// always accepted in DATA and dropped (counted, overflow flagged) while the FIFO
// is full; when undefined, a full FIFO backpressures the source instead.
module sample_fifo_writer
  import sfw_pkg::*;
#(
  parameter int          FRAME_LEN = 256,
  parameter logic [31:0] SYNC_WORD = SFW_SYNC_WORD
) (
  input  logic                   wr_clk,
  input  logic                   wr_rst_n,
  sample_fifo_writer_if.master   bus,
  input  logic                   enable,
  input  logic                   clr_ovf,
  output logic                   busy,
  output logic                   frame_done,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            drop_cnt,
  output logic                   overflow,
  output sfw_state_e             dbg_state
);

  localparam logic [SFW_LEN_W-1:0] LEN_FIELD = SFW_LEN_W'(FRAME_LEN);
  localparam logic [15:0]          LAST_IDX  = 16'(FRAME_LEN - 1);

  sfw_state_e  state, state_nxt;
  logic [15:0] smp_cnt;
  logic        data_wr;

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  // State register; reset abandons any partial frame.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Next state and zero-latency FIFO write / sample ready outputs.
  always_comb begin
    state_nxt       = state;
    bus.s_ready     = 1'b0;
    bus.fifo_wr_en  = 1'b0;
    bus.fifo_din    = '0;
    data_wr         = 1'b0;
    frame_done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        bus.fifo_din = SYNC_WORD;
        if (!bus.fifo_full) begin
          bus.fifo_wr_en = 1'b1;
          state_nxt      = ST_SEQ;
        end
      end
      ST_SEQ: begin
        bus.fifo_din = sfw_seq_word(frame_cnt, LEN_FIELD);
        if (!bus.fifo_full) begin
          bus.fifo_wr_en = 1'b1;
          state_nxt      = ST_DATA;
        end
      end
      ST_DATA: begin
        bus.fifo_din = {bus.s_i, bus.s_q};
`ifdef SFW_DROP_EN
        bus.s_ready  = 1'b1;
`else
        bus.s_ready  = !bus.fifo_full;
`endif
        data_wr        = bus.s_valid && bus.s_ready && !bus.fifo_full;
        bus.fifo_wr_en = data_wr;
        if (data_wr && (smp_cnt == LAST_IDX)) begin
          frame_done = 1'b1;
          state_nxt  = enable ? ST_HDR : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sample position within the frame and completed-frame count.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      smp_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      if (data_wr) smp_cnt <= (smp_cnt == LAST_IDX) ? 16'd0 : smp_cnt + 16'd1;
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

`ifdef SFW_DROP_EN
  logic drop_evt;
  assign drop_evt = (state == ST_DATA) && bus.s_valid && bus.fifo_full;

  sat_counter u_drop_cnt (
    .clk   (wr_clk),
    .rst_n (wr_rst_n),
    .inc   (drop_evt),
    .count (drop_cnt)
  );

  // Sticky overflow; a new drop wins over a coincident clear.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n)     overflow <= 1'b0;
    else if (drop_evt) overflow <= 1'b1;
    else if (clr_ovf)  overflow <= 1'b0;
  end
`else
  logic unused_clr_ovf;
  assign unused_clr_ovf = clr_ovf;
  assign drop_cnt       = '0;
  assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_sample_fifo_writer.sv
// Bench for sample_fifo_writer with FRAME_LEN=4; follows SFW_DROP_EN when defined.
module tb_sample_fifo_writer;
  import sfw_pkg::*;

  localparam int          FL   = 4;
  localparam logic [31:0] SYNC = 32'h5344_5246;
`ifdef SFW_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        wr_clk   = 1'b0;
  logic        wr_rst_n = 1'b0;
  logic        enable   = 1'b0;
  logic        clr_ovf  = 1'b0;
  logic        busy, frame_done, overflow;
  logic [15:0] frame_cnt, drop_cnt;
  sfw_state_e  dbg_state;

  sample_fifo_writer_if bus ();

  sample_fifo_writer #(.FRAME_LEN(FL)) dut (
    .wr_clk     (wr_clk),
    .wr_rst_n   (wr_rst_n),
    .bus        (bus),
    .enable     (enable),
    .clr_ovf    (clr_ovf),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
  );

  always #5 wr_clk = ~wr_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic vld, input logic full,
                       input logic [15:0] si, input logic [15:0] sq);
    enable        = en;
    bus.s_valid   = vld;
    bus.fifo_full = full;
    bus.s_i       = si;
    bus.s_q       = sq;
  endtask

  task automatic reset_dut();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    clr_ovf  = 1'b0;
    wr_rst_n = 1'b0;
    repeat (3) @(posedge wr_clk);
    @(negedge wr_clk);
    wr_rst_n = 1'b1;
    @(posedge wr_clk);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge wr_clk);
    #1;
  endtask

  // ---------------- reference model / scoreboard ----------------
  // A frame is FL+2 words: SYNC, {frame#, FL}, then accepted samples in order.
  logic [31:0] exp_q[$];
  bit          mon_en     = 1'b0;
  int          mon_pos    = 0;
  int          mon_frames = 0;
  int          mon_drops  = 0;
  bit          hs_last    = 1'b0;

  always @(negedge wr_clk) begin
    if (mon_en) begin
      logic [31:0] exp_w;
      hs_last = bus.s_valid && bus.s_ready;
      if (hs_last) begin
        if (bus.fifo_full) mon_drops++;
        else exp_q.push_back({bus.s_i, bus.s_q});
      end
      if (bus.fifo_wr_en) begin
        check("wr_while_full", bus.fifo_full, 1'b0);
        if (mon_pos == 0)      exp_w = SYNC;
        else if (mon_pos == 1) exp_w = {mon_frames[15:0], 16'(FL)};
        else if (exp_q.size() == 0) exp_w = 32'hDEAD_BEEF;
        else                   exp_w = exp_q.pop_front();
        check("stream_word", bus.fifo_din, exp_w);
        check("frame_done_pos", frame_done, (mon_pos == FL + 1));
        if (mon_pos == FL + 1) begin
          mon_pos = 0;
          mon_frames++;
        end else begin
          mon_pos++;
        end
      end else if (frame_done) begin
        check("frame_done_no_write", frame_done, 1'b0);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        en, vld, full;
    logic [15:0] si, sq;
    logic [31:0] din;
    logic        wr, rdy, bsy, done;
    logic [15:0] fcnt, dcnt;
    logic        ovf;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic vld, input logic full,
                              input logic [15:0] si, input logic [15:0] sq,
                              input logic [31:0] din, input logic wr, input logic rdy,
                              input logic bsy, input logic done, input logic [15:0] fcnt,
                              input logic [15:0] dcnt, input logic ovf);
    vec_t v;
    v.en = en; v.vld = vld; v.full = full; v.si = si; v.sq = sq;
    v.din = din; v.wr = wr; v.rdy = rdy; v.bsy = bsy; v.done = done;
    v.fcnt = fcnt; v.dcnt = dcnt; v.ovf = ovf;
    return v;
  endfunction

  vec_t vecs[14];

  initial begin
    int n_wr, n_done, n_data;
    bit seen_done;
    logic [31:0] first_w[2];

    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

    // ---- table: reset state, header stall under full, one frame, next header ----
    vecs[0]  = mk(1, 0, 0, 16'h0000, 16'h0000, 32'h0,          0, 0,    0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 1, 16'h0000, 16'h0000, SYNC,           0, 0,    1, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 1, 16'h0000, 16'h0000, SYNC,           0, 0,    1, 0, 0, 0, 0);
    vecs[3]  = mk(1, 0, 1, 16'h0000, 16'h0000, SYNC,           0, 0,    1, 0, 0, 0, 0);
    vecs[4]  = mk(1, 0, 0, 16'h0000, 16'h0000, SYNC,           1, 0,    1, 0, 0, 0, 0);
    vecs[5]  = mk(1, 0, 0, 16'h0000, 16'h0000, 32'h0000_0004,  1, 0,    1, 0, 0, 0, 0);
    vecs[6]  = mk(1, 1, 0, 16'h1111, 16'h2222, 32'h1111_2222,  1, 1,    1, 0, 0, 0, 0);
    vecs[7]  = mk(1, 0, 0, 16'h0000, 16'h0000, 32'h0,          0, 1,    1, 0, 0, 0, 0);
    vecs[8]  = mk(1, 1, 0, 16'h3333, 16'h4444, 32'h3333_4444,  1, 1,    1, 0, 0, 0, 0);
    vecs[9]  = mk(1, 1, 1, 16'h5555, 16'h6666, 32'h5555_6666,  0, DROP, 1, 0, 0, 0, 0);
    vecs[10] = mk(1, 1, 0, 16'h5555, 16'h6666, 32'h5555_6666,  1, 1,    1, 0, 0, 16'(DROP), DROP);
    vecs[11] = mk(1, 1, 0, 16'h7777, 16'h8888, 32'h7777_8888,  1, 1,    1, 1, 0, 16'(DROP), DROP);
    vecs[12] = mk(1, 0, 0, 16'h0000, 16'h0000, SYNC,           1, 0,    1, 0, 1, 16'(DROP), DROP);
    vecs[13] = mk(1, 0, 0, 16'h0000, 16'h0000, 32'h0001_0004,  1, 0,    1, 0, 1, 16'(DROP), DROP);

    reset_dut();
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].en, vecs[i].vld, vecs[i].full, vecs[i].si, vecs[i].sq);
      @(negedge wr_clk);
      check($sformatf("vec%0d {wr,din,rdy,busy,done,fcnt,dcnt,ovf}", i),
            {bus.fifo_wr_en, bus.fifo_din, bus.s_ready, busy, frame_done, frame_cnt, drop_cnt, overflow},
            {vecs[i].wr, vecs[i].din, vecs[i].rdy, vecs[i].bsy, vecs[i].done,
             vecs[i].fcnt, vecs[i].dcnt, vecs[i].ovf});
      next_cycle();
    end

    // ---- enable falls after data sample 2: frame still completes, then idle ----
    reset_dut();
    drive(1'b1, 1'b1, 1'b0, 16'hABCD, 16'h1234);
    n_wr = 0; n_done = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge wr_clk);
      seen_done = frame_done;
      if (bus.fifo_wr_en) n_wr++;
      if (frame_done) n_done++;
      next_cycle();
      if (seen_done) check("busy_after_last_frame", busy, 1'b0);
      if (n_wr == 4) enable = 1'b0;
    end
    check("writes_after_enable_drop", n_wr, 6);
    check("frame_done_pulses", n_done, 1);

    // ---- reset mid-DATA: immediate reset values, next frame restarts at sequence 0 ----
    reset_dut();
    drive(1'b1, 1'b1, 1'b0, 16'h0F0F, 16'hF0F0);
    n_wr = 0;
    for (int k = 0; k < 40 && n_wr < 9; k++) begin
      @(negedge wr_clk);
      if (bus.fifo_wr_en) n_wr++;
      if (n_wr < 9) next_cycle();
    end
    check("mid_frame_writes", n_wr, 9);
    check("frame_cnt_before_reset", frame_cnt, 16'd1);
    @(posedge wr_clk);
    #2;
    wr_rst_n = 1'b0;
    #1;
    check("async_reset_outputs {wr,din,rdy,busy,done,fcnt,dcnt,ovf}",
          {bus.fifo_wr_en, bus.fifo_din, bus.s_ready, busy, frame_done, frame_cnt, drop_cnt, overflow},
          68'h0);
    @(negedge wr_clk);
    wr_rst_n = 1'b1;
    n_wr = 0;
    for (int k = 0; k < 20 && n_wr < 2; k++) begin
      @(posedge wr_clk);
      @(negedge wr_clk);
      if (bus.fifo_wr_en) begin
        first_w[n_wr] = bus.fifo_din;
        n_wr++;
      end
    end
    check("restart_header_count", n_wr, 2);
    check("restart_sync_word", first_w[0], SYNC);
    check("restart_seq_word", first_w[1], 32'h0000_0004);

    // ---- full while valid in DATA: drop or backpressure, counter unaffected ----
    reset_dut();
    drive(1'b1, 1'b0, 1'b0, 16'hA5A5, 16'h5A5A);
    repeat (3) next_cycle();
    check("in_data_state", dbg_state, ST_DATA);
    drive(1'b0, 1'b1, 1'b1, 16'hA5A5, 16'h5A5A);
    for (int k = 0; k < 5; k++) begin
      @(negedge wr_clk);
      check($sformatf("full_ready_c%0d", k), {bus.s_ready, bus.fifo_wr_en}, {DROP, 1'b0});
      next_cycle();
    end
    @(negedge wr_clk);
    check("drop_cnt_after_5", drop_cnt, DROP ? 16'd5 : 16'd0);
    check("overflow_after_5", overflow, DROP);
`ifdef SFW_DROP_EN
    next_cycle();
    for (int k = 0; k < 70000 - 6; k++) next_cycle();
    @(negedge wr_clk);
    check("drop_cnt_saturated", drop_cnt, 16'hFFFF);
    next_cycle();
    clr_ovf = 1'b1;
    next_cycle();
    clr_ovf = 1'b0;
    @(negedge wr_clk);
    check("overflow_set_wins_clear", overflow, 1'b1);
    bus.s_valid = 1'b0;
    clr_ovf     = 1'b1;
    next_cycle();
    clr_ovf     = 1'b0;
    @(negedge wr_clk);
    check("overflow_cleared", overflow, 1'b0);
    check("drop_cnt_held", drop_cnt, 16'hFFFF);
`endif
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 16'hA5A5, 16'h5A5A);
    n_data = 0;
    n_done = 0;
    for (int k = 0; k < 10 && n_done == 0; k++) begin
      @(negedge wr_clk);
      if (bus.fifo_wr_en) n_data++;
      if (frame_done) begin
        n_done++;
        check("samples_to_frame_done", n_data, FL);
      end
      next_cycle();
    end
    check("frame_done_after_full", n_done, 1);

    // ---- randomized traffic against the frame model ----
    reset_dut();
    exp_q.delete();
    mon_pos = 0; mon_frames = 0; mon_drops = 0; hs_last = 1'b0;
    mon_en = 1'b1;
    for (int k = 0; k < 500; k++) begin
      if (!bus.s_valid || hs_last) begin
        bus.s_valid = ($urandom_range(0, 3) != 0);
        bus.s_i     = 16'($urandom);
        bus.s_q     = 16'($urandom);
      end
      bus.fifo_full = ($urandom_range(0, 3) == 0);
      enable        = ($urandom_range(0, 7) != 0);
      next_cycle();
    end
    enable        = 1'b0;
    bus.fifo_full = 1'b0;
    begin
      int k;
      for (k = 0; k < 100 && busy; k++) begin
        if (!bus.s_valid || hs_last) begin
          bus.s_i = 16'($urandom);
          bus.s_q = 16'($urandom);
        end
        bus.s_valid = 1'b1;
        next_cycle();
      end
      check("drain_within_budget", busy, 1'b0);
    end
    bus.s_valid = 1'b0;
    next_cycle();
    mon_en = 1'b0;
    check("rand_frame_boundary", mon_pos, 0);
    check("rand_pending_samples", exp_q.size(), 0);
    check("rand_frame_cnt", frame_cnt, 16'(mon_frames));
    check("rand_drop_cnt", drop_cnt, (mon_drops > 65535) ? 16'hFFFF : 16'(mon_drops));
    check("rand_overflow", overflow, (mon_drops > 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_fifo_writer.md
SAMPLE_FIFO_WRITER -- requirements
Module: sample_fifo_writer

Interface
REQ-001 Parameter FRAME_LEN, 256, data samples per frame; legal range 1..65535.
REQ-002 Parameter SYNC_WORD, 32'h5344_5246, first header word of every frame.
REQ-003 wr_clk  in  1  clock; all logic runs on this single clock.
REQ-004 wr_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 enable  in  1  level; 1 starts framing, 0 stops after the current frame completes.
REQ-006 s_valid  in  1  sample valid from the ADC/DDC path.
REQ-007 s_i  in  16  in-phase sample.
REQ-008 s_q  in  16  quadrature sample.
REQ-009 s_ready  out  1  sample accepted when s_valid=1 and s_ready=1 in the same cycle.
REQ-010 fifo_din  out  32  write data to the async FIFO write port.
REQ-011 fifo_wr_en  out  1  write strobe to the async FIFO.
REQ-012 fifo_full  in  1  FIFO full flag, write-domain.
REQ-013 clr_ovf  in  1  one-cycle pulse; clears overflow.
REQ-014 busy  out  1  state != IDLE.
REQ-015 frame_done  out  1  one-cycle pulse on the last data write of a frame.
REQ-016 frame_cnt  out  16  completed frames; wraps 0xFFFF->0x0000.
REQ-017 drop_cnt  out  16  dropped samples; saturates at 0xFFFF.
REQ-018 overflow  out  1  sticky drop indicator.

Function
REQ-019 The FSM SHALL have states IDLE, HDR, SEQ, DATA.
REQ-020 IDLE->HDR when enable=1; HDR->SEQ on a write; SEQ->DATA on a write; DATA->HDR after FRAME_LEN data writes if enable=1, else DATA->IDLE.
REQ-021 HDR SHALL write SYNC_WORD; SEQ SHALL write {frame_cnt[15:0], FRAME_LEN[15:0]}; DATA SHALL write {s_i, s_q}.
REQ-022 fifo_wr_en and fifo_din SHALL be combinational, zero latency from state/inputs.
REQ-023 fifo_wr_en SHALL never be 1 while fifo_full=1.
REQ-024 In HDR and SEQ the write SHALL occur on the first cycle with fifo_full=0; otherwise the state holds.
REQ-025 In DATA, fifo_wr_en = s_valid & s_ready & !fifo_full.
REQ-026 s_ready SHALL be 0 in IDLE, HDR and SEQ.
REQ-027 The sample counter SHALL advance only on an actual data write; dropped samples never count toward FRAME_LEN.
REQ-028 frame_cnt SHALL increment in the same cycle as frame_done, so the first frame carries sequence 0.
REQ-029 When enable falls mid-frame, the frame SHALL complete all FRAME_LEN samples before IDLE.
REQ-030 When enable=0 in HDR or SEQ, the header and frame SHALL still complete.
REQ-031 When overflow is set and clr_ovf=1 in the same cycle, set SHALL win.

Reset
REQ-032 On wr_rst_n=0, immediately: state IDLE, s_ready=0, fifo_wr_en=0, fifo_din=0, busy=0, frame_done=0, frame_cnt=0, drop_cnt=0, overflow=0, sample counter=0.
REQ-033 Reset mid-frame SHALL abandon the partial frame; the next frame SHALL start with HDR and sequence 0.

Configuration
REQ-034 Macro SFW_DROP_EN defined: in DATA, s_ready=1 always; a sample with s_valid=1 and fifo_full=1 SHALL be dropped, drop_cnt incremented (saturating) and overflow set.
REQ-035 Macro SFW_DROP_EN undefined: in DATA, s_ready=!fifo_full (backpressure); drop_cnt and overflow SHALL be tied to 0.

Structure
REQ-036 Shared package sfw_pkg SHALL hold the FSM state typedef, the default SYNC_WORD and the header field widths.
REQ-037 Sub-module sat_counter (16-bit, increment, saturate at all-ones, async clear) SHALL implement drop_cnt.

Verification (FRAME_LEN=4)
REQ-038 Reset, enable=1, s_valid=1, full=0 -> FIFO writes 0x53445246, 0x00000004, 4 samples, 0x53445246, 0x00010004; frame_cnt=1 after the first frame_done.
REQ-039 fifo_full=1 for 3 cycles while in HDR -> no fifo_wr_en; SYNC_WORD written on the cycle full falls.
REQ-040 SFW_DROP_EN defined, full=1 for 5 valid DATA cycles -> drop_cnt=5, overflow=1, sample counter unchanged; undefined -> s_ready=0, drop_cnt=0.
REQ-041 enable=0 after data sample 2 -> samples 3-4 written, frame_done pulses once, busy=0 the next cycle.
REQ-042 wr_rst_n asserted mid-DATA -> all outputs at reset values the same cycle; the next header second word is 0x00000004.
REQ-043 70000 drops -> drop_cnt=0xFFFF; clr_ovf coincident with a drop -> overflow stays 1.
